// File: rtl/ad9516_spi_cfg.sv
// ad9516_spi_cfg: streams a 24-bit register table to an AD9516 over write-only SPI, then issues an IO update.
module ad9516_spi_cfg #(
  parameter int CLK_DIV  = 5,
  parameter int TBL_LEN  = 64,
  parameter int WAIT_CYC = 500_000,
  parameter int CS_GAP   = 10
) (
  input  logic        clk_50m,
  input  logic        hw_arst,
  input  logic        chip_rst_n,
  input  logic        cfg_start,
  output logic [7:0]  tbl_addr,
  input  logic [23:0] tbl_data,
  output logic        spi_csb,
  output logic        spi_sclk,
  output logic        spi_sdio,
  output logic        cfg_busy,
  output logic        cfg_done
);
  typedef enum logic [2:0] {IDLE, WAIT_RST, FETCH, LOAD, SHIFT, GAP, UPDATE, DONE} state_t;
  localparam logic [31:0] LP_WAIT = 32'(WAIT_CYC - 1);
  localparam logic [31:0] LP_GAP  = 32'(CS_GAP - 1);
  localparam logic [7:0]  LP_DIV  = 8'(CLK_DIV - 1);
  localparam logic [7:0]  LP_LAST = 8'(TBL_LEN - 1);
  localparam logic [23:0] LP_UPD  = {3'b000, 13'h0232, 8'h01};
  state_t      r_state;
  logic [1:0]  r_rst_sync;
  logic [31:0] r_cnt;
  logic [7:0]  r_div, r_addr;
  logic [4:0]  r_bit;
  logic [23:0] r_sr;
  logic        r_upd, r_csb, r_sclk, r_sdio, r_busy, r_done;
  logic        w_abort, w_unused;
  logic [23:0] w_word;
  // Frame word: write bit, 1-byte length, 13-bit register address, data byte.
  assign w_word   = (r_state == UPDATE) ? LP_UPD : {3'b000, tbl_data[20:8], tbl_data[7:0]};
  assign w_abort  = !chip_rst_n && !(r_state inside {IDLE, WAIT_RST, DONE});
  assign w_unused = &{1'b0, tbl_data[23:21]};
  assign tbl_addr = r_addr;
  assign spi_csb  = r_csb;
  assign spi_sclk = r_sclk;
  assign spi_sdio = r_sdio;
  assign cfg_busy = r_busy;
  assign cfg_done = r_done;
  always_ff @(posedge clk_50m or posedge hw_arst)
    if (hw_arst) r_rst_sync <= 2'b11;
    else r_rst_sync <= {r_rst_sync[0], 1'b0};
  always_ff @(posedge clk_50m or posedge hw_arst) begin
    if (hw_arst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_div   <= '0;
      r_addr  <= '0;
      r_bit   <= '0;
      r_sr    <= '0;
      r_upd   <= 1'b0;
      r_csb   <= 1'b1;
      r_sclk  <= 1'b0;
      r_sdio  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (r_rst_sync[1]) begin
      r_state <= IDLE;
    end else if (w_abort) begin
      r_state <= WAIT_RST;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_upd   <= 1'b0;
      r_csb   <= 1'b1;
      r_sclk  <= 1'b0;
      r_sdio  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= WAIT_RST;
          r_busy  <= 1'b1;
          r_cnt   <= '0;
        end
        WAIT_RST: begin
          r_cnt <= chip_rst_n ? r_cnt + 32'd1 : '0;
          if (chip_rst_n && r_cnt == LP_WAIT) begin
            r_state <= FETCH;
            r_addr  <= '0;
            r_upd   <= 1'b0;
          end
        end
        FETCH: r_state <= LOAD;
        LOAD, UPDATE: begin
          r_sr    <= w_word;
          r_sdio  <= w_word[23];
          r_csb   <= 1'b0;
          r_sclk  <= 1'b0;
          r_div   <= '0;
          r_bit   <= '0;
          r_upd   <= (r_state == UPDATE);
          r_state <= SHIFT;
        end
        SHIFT: begin
          r_div <= (r_div == LP_DIV) ? '0 : r_div + 8'd1;
          if (r_div == LP_DIV) begin
            if (!r_sclk) begin
              r_sclk <= 1'b1;
              r_bit  <= r_bit + 5'd1;
            end else if (r_bit == 5'd24) begin
              r_sclk  <= 1'b0;
              r_csb   <= 1'b1;
              r_sdio  <= 1'b0;
              r_cnt   <= '0;
              r_state <= GAP;
            end else begin
              r_sclk <= 1'b0;
              r_sr   <= {r_sr[22:0], 1'b0};
              r_sdio <= r_sr[22];
            end
          end
        end
        GAP: begin
          r_cnt <= r_cnt + 32'd1;
          if (r_cnt == LP_GAP) begin
            if (r_upd) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else if (r_addr < LP_LAST) begin
              r_addr  <= r_addr + 8'd1;
              r_state <= FETCH;
            end else r_state <= UPDATE;
          end
        end
        DONE: if (!chip_rst_n || cfg_start) begin
          r_state <= WAIT_RST;
          r_busy  <= 1'b1;
          r_done  <= 1'b0;
          r_cnt   <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ad9516_spi_cfg.sv
// tb_ad9516_spi_cfg: stimulus pushes expected SPI words; a pin-level monitor decodes frames and scores them.
module tb_ad9516_spi_cfg;
  localparam int CLK_DIV   = 2;
  localparam int TBL_LEN   = 3;
  localparam int WAIT_CYC  = 20;
  localparam int CS_GAP    = 4;
  localparam int FRAME_LEN = 48 * CLK_DIV;
  localparam int FIRST_CSB = WAIT_CYC + 2;
  logic clk_50m = 1'b0, hw_arst = 1'b1, chip_rst_n = 1'b1, cfg_start = 1'b0;
  logic [7:0]  tbl_addr;
  logic [23:0] tbl_data = '0;
  logic spi_csb, spi_sclk, spi_sdio, cfg_busy, cfg_done;
  logic [23:0] tbl [TBL_LEN] = '{24'h000018, 24'h00107C, 24'h019000};
  logic [23:0] exp_words [4] = '{24'h000018, 24'h00107C, 24'h019000, 24'h023201};
  logic [23:0] exp_q [$];
  int checks = 0, errors = 0;
  int frames = 0, bits = 0, low = 0, gap = 1000, stab = 0, abort_bits = 0;
  bit abort_pending = 0, seen = 0, tbad = 0, idle_bad = 0;
  logic [23:0] word = '0;
  logic p_csb = 1'b1, p_sclk = 1'b0, p_sdio = 1'b0;
  ad9516_spi_cfg #(.CLK_DIV(CLK_DIV), .TBL_LEN(TBL_LEN), .WAIT_CYC(WAIT_CYC), .CS_GAP(CS_GAP)) dut (
    .clk_50m(clk_50m), .hw_arst(hw_arst), .chip_rst_n(chip_rst_n), .cfg_start(cfg_start),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data), .spi_csb(spi_csb), .spi_sclk(spi_sclk),
    .spi_sdio(spi_sdio), .cfg_busy(cfg_busy), .cfg_done(cfg_done)
  );
  always #5 clk_50m = ~clk_50m;
  always @(posedge clk_50m) tbl_data <= (tbl_addr < 8'(TBL_LEN)) ? tbl[tbl_addr[1:0]] : 24'h0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Pin-level frame decoder and scoreboard.
  always @(posedge clk_50m) begin
    #1;
    stab = (spi_sdio === p_sdio) ? stab + 1 : 0;
    if (!spi_csb) begin
      if (p_csb) begin
        if (seen) chk("gap", 32'(gap >= CS_GAP && !idle_bad), 1);
        bits = 0; low = 0; word = '0; tbad = 0; seen = 1;
      end else if (spi_sdio !== p_sdio && !(p_sclk && !spi_sclk)) tbad = 1;
      low++;
      if (spi_sclk && !p_sclk) begin
        bits++;
        word = {word[22:0], spi_sdio};
        if (stab < CLK_DIV) tbad = 1;
      end
    end else begin
      if (!p_csb) begin
        if (abort_pending) begin
          chk("abort_bits", bits, abort_bits);
          abort_pending = 0;
        end else if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_frame: got %06h expected none", word);
        end else begin
          chk("word", word, exp_q.pop_front());
          chk("csb_low", low, FRAME_LEN);
          chk("nbits", bits, 24);
          chk("sdio_timing", 32'(tbad), 0);
          frames++;
        end
        gap = 0; idle_bad = 0;
      end
      gap++;
      if (spi_sclk) idle_bad = 1;
    end
    p_csb = spi_csb; p_sclk = spi_sclk; p_sdio = spi_sdio;
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk_50m);
  endtask
  task automatic push_all();
    foreach (exp_words[i]) exp_q.push_back(exp_words[i]);
  endtask
  task automatic wait_done(input string name);
    int n = 0;
    while (!cfg_done && n < 3000) begin @(negedge clk_50m); n++; end
    chk(name, 32'(cfg_done), 1);
  endtask
  task automatic time_to_csb(input string name);
    int n = 0;
    do begin @(negedge clk_50m); n++; end while (spi_csb && n < 200);
    chk(name, n, FIRST_CSB);
  endtask
  task automatic wait_bit(input int f, input int b);
    int n = 0;
    while (!(frames == f && bits == b && !spi_csb) && n < 3000) begin @(negedge clk_50m); n++; end
    chk("reach_bit", 32'(n < 3000), 1);
  endtask
  initial begin
    int f0, n, lows;
    cyc(3);
    chk("rst_csb", spi_csb, 1); chk("rst_sclk", spi_sclk, 0); chk("rst_sdio", spi_sdio, 0);
    chk("rst_addr", tbl_addr, 0); chk("rst_busy", cfg_busy, 0); chk("rst_done", cfg_done, 0);
    push_all();
    hw_arst = 1'b0;
    n = 0;
    while (!cfg_busy && n < 20) begin @(negedge clk_50m); n++; end
    chk("busy_on", cfg_busy, 1);
    time_to_csb("first_csb");
    wait_done("done1");
    chk("q_empty1", exp_q.size(), 0); chk("busy_off", cfg_busy, 0);
    chip_rst_n = 1'b0; cyc(1);
    chk("lost_cfg_done", cfg_done, 0); chk("lost_cfg_busy", cfg_busy, 1);
    push_all(); cyc(3); chip_rst_n = 1'b1;
    time_to_csb("relock_csb");
    wait_done("done2");
    f0 = frames;
    cfg_start = 1'b1; cyc(1); cfg_start = 1'b0;
    chk("start_done", cfg_done, 0); chk("start_busy", cfg_busy, 1);
    push_all();
    wait_bit(f0 + 2, 3);
    cfg_start = 1'b1; cyc(1); cfg_start = 1'b0;
    wait_done("done3");
    chk("reconfig_frames", frames - f0, 4); chk("q_empty3", exp_q.size(), 0);
    f0 = frames;
    cfg_start = 1'b1; cyc(1); cfg_start = 1'b0;
    exp_q.push_back(exp_words[0]);
    wait_bit(f0 + 1, 10);
    abort_bits = 10; abort_pending = 1; chip_rst_n = 1'b0;
    @(posedge clk_50m); #1;
    chk("abort_csb", spi_csb, 1); chk("abort_sclk", spi_sclk, 0); chk("abort_sdio", spi_sdio, 0);
    chk("abort_addr", tbl_addr, 0); chk("abort_done", cfg_done, 0);
    cyc(5); push_all(); chip_rst_n = 1'b1;
    time_to_csb("abort_restart");
    wait_done("done4");
    chk("q_empty4", exp_q.size(), 0);
    hw_arst = 1'b1; cyc(2);
    chk("arst_done", cfg_done, 0);
    chip_rst_n = 1'b0; hw_arst = 1'b0;
    lows = 0;
    repeat (100) begin @(negedge clk_50m); if (!spi_csb) lows++; end
    chk("hold_csb", lows, 0); chk("hold_busy", cfg_busy, 1);
    push_all(); chip_rst_n = 1'b1;
    time_to_csb("hold_first_csb");
    wait_done("done5");
    f0 = frames;
    cfg_start = 1'b1; cyc(1); cfg_start = 1'b0;
    wait_bit(f0, 5);
    abort_bits = 5; abort_pending = 1;
    #2 hw_arst = 1'b1; #1;
    chk("arst_csb", spi_csb, 1); chk("arst_sclk", spi_sclk, 0); chk("arst_sdio", spi_sdio, 0);
    chk("arst_addr", tbl_addr, 0); chk("arst_busy", cfg_busy, 0); chk("arst_done2", cfg_done, 0);
    cyc(2); push_all(); hw_arst = 1'b0;
    wait_done("done6");
    chk("q_empty_end", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
